// File: rtl/data_memory_hs.sv
// data_memory_hs: 32-bit-wide data memory for the MEM stage with a valid/ready
// request channel and a registered one-cycle response strobe. Responses come
// LATENCY edges after acceptance; byte/half/word accesses with lane writes and
// signed/unsigned load extension.
// Build option: define DMEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with resp_err; when undefined they are forced aligned.
module data_memory_hs #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Captured request
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] widx_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;

    // Access decode and datapath
    logic              accept;
    logic              finish;
    logic              wr_en;
    logic              err_c;
    logic [1:0]        eff_off;
    logic [3:0]        lane_mask;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       wr_shift;
    logic [31:0]       load_val;

    // Response registers
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Upper address bits only wrap the address and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign accept = req_valid && req_ready;
    assign finish = (state_q == S_BUSY) && (cnt_q == '0);
    assign wr_en  = finish && write_q && !err_c;

    // FSM state and latency counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and handshake outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        busy       = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                req_ready  = 1'b1;
                if (req_valid) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture every request field at the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q  <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            widx_q   <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            widx_q   <= req_addr[ADDR_W+1:2];
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
        end
    end

    // Decode size/alignment into lane offset, lane mask and error
    always_comb begin
        eff_off   = off_q;
        err_c     = 1'b0;
        lane_mask = 4'b0000;
        case (size_q)
            2'b00: lane_mask = 4'b0001 << off_q;
            2'b01: begin
`ifdef DMEM_ALIGN_CHECK_EN
                err_c   = off_q[0];
`else
                eff_off = {off_q[1], 1'b0};
`endif
                lane_mask = 4'b0011 << eff_off;
            end
            2'b10: begin
`ifdef DMEM_ALIGN_CHECK_EN
                err_c   = (off_q != 2'b00);
`else
                eff_off = 2'b00;
`endif
                lane_mask = 4'b1111;
            end
            default: err_c = 1'b1;
        endcase
    end

    // Storage: one register per word, power-up value equal to its index.
    // Not reset, so a reset never disturbs memory contents.
    logic [31:0] words [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [31:0] word_q = 32'(i);

        // Commit the addressed lanes of a store on the edge entering RESP
        always_ff @(posedge clk) begin
            if (wr_en && (widx_q == ADDR_W'(i))) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (lane_mask[k]) begin
                        word_q[8*k +: 8] <= wr_shift[8*k +: 8];
                    end
                end
            end
        end

        assign words[i] = word_q;
    end

    assign rd_word  = words[widx_q];
    assign rd_shift = rd_word >> {eff_off, 3'b000};
    assign wr_shift = wdata_q << {eff_off, 3'b000};

    // Right-justify the addressed lanes and extend to 32 bits
    always_comb begin
        load_val = '0;
        case (size_q)
            2'b00: load_val = signed_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                       : {24'h000000, rd_shift[7:0]};
            2'b01: load_val = signed_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                       : {16'h0000, rd_shift[15:0]};
            2'b10: load_val = rd_shift;
            default: load_val = '0;
        endcase
    end

    // Response data/error are non-zero only for the RESP cycle
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (finish) begin
            err_d = err_c;
            if (!write_q && !err_c) begin
                rdata_d = load_val;
            end
        end
    end

    // Response register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Testbench for data_memory_hs: directed vector table, reset-mid-operation
// sequence, and randomized accesses checked against a byte-level reference model.
module tb_data_memory_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst3, valid0, valid3;
    logic        req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        ready0, rv0, err0, busy0;
    logic [31:0] rd0;
    logic        ready3, rv3, err3, busy3;
    logic [31:0] rd3;

    data_memory_hs #(.ADDR_W(8), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst0), .req_valid(valid0), .req_ready(ready0),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0),
        .resp_rdata(rd0), .resp_err(err0), .busy(busy0)
    );

    data_memory_hs #(.ADDR_W(8), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req_valid(valid3), .req_ready(ready3),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3),
        .resp_rdata(rd3), .resp_err(err3), .busy(busy3)
    );

    // Selected DUT view (0: LATENCY=2, 1: LATENCY=3)
    logic        dsel;
    logic        m_ready, m_rv, m_err, m_busy;
    logic [31:0] m_rd;
    always_comb begin
        m_ready = dsel ? ready3 : ready0;
        m_rv    = dsel ? rv3    : rv0;
        m_err   = dsel ? err3   : err0;
        m_busy  = dsel ? busy3  : busy0;
        m_rd    = dsel ? rd3    : rd0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: byte-addressed view of each DUT's memory
    logic [31:0] mdl [2][256];

    task automatic model(input int d, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int unsigned nb, lane, idx;
        logic [31:0] addr;
        longint v;
        rd   = '0;
        er   = 1'b0;
        addr = a;
        if (sz == 2'b11) begin
            er = 1'b1;
            return;
        end
        nb = 1 << sz;
`ifdef DMEM_ALIGN_CHECK_EN
        if (addr % nb != 0) begin
            er = 1'b1;
            return;
        end
`else
        addr = addr - addr % nb;
`endif
        idx  = (addr / 4) % 256;
        lane = addr % 4;
        if (w) begin
            for (int unsigned b = 0; b < nb; b++)
                mdl[d][idx][8*(lane+b) +: 8] = wd[8*b +: 8];
        end else begin
            v = 0;
            for (int unsigned b = 0; b < nb; b++)
                v = v + (longint'(mdl[d][idx][8*(lane+b) +: 8]) << (8*b));
            if (sg && nb < 4 && v >= (longint'(1) << (8*nb - 1)))
                v = v - (longint'(1) << (8*nb));
            rd = v[31:0];
        end
    endtask

    // One request on the selected DUT; returns at #1 after the response edge
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int lat;
        int exp_lat;
        exp_lat = dsel ? 3 : 2;
        @(negedge clk);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        if (dsel) valid3 = 1'b1; else valid0 = 1'b1;
        check({tag, ".ready"}, {31'b0, m_ready}, 32'd1);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid3 = 1'b0;
        // Inputs changing after acceptance must not matter
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        check({tag, ".busy"}, {31'b0, m_busy}, 32'd1);
        check({tag, ".ready_busy"}, {31'b0, m_ready}, 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!m_rv && lat < 20);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy_resp"}, {31'b0, m_busy}, 32'd0);
        check({tag, ".rdata"}, m_rd, exp_rd);
        check({tag, ".err"}, {31'b0, m_err}, {31'b0, exp_err});
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, {31'b0, m_ready}, 32'd1);
        check({tag, ".resp_valid"}, {31'b0, m_rv}, 32'd0);
        check({tag, ".rdata"}, m_rd, 32'd0);
        check({tag, ".err"}, {31'b0, m_err}, 32'd0);
        check({tag, ".busy"}, {31'b0, m_busy}, 32'd0);
    endtask

    initial begin
        logic        w, sg, eer, seen;
        logic [1:0]  sz;
        logic [31:0] a, wd, erd;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                mdl[d][i] = 32'(i);

        // Directed table: {write, size, signed, addr, wdata, exp rdata, exp err}
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'h00000005, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h8,   32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h8,   32'h0,        32'h000000EF, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'hB,   32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'hA,   32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h8,   32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h9,   32'h00000077, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        32'hDEAD77EF, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h6,   32'h0,        32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h5,   32'h0,        32'h00000000, 1'b1};
`else
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h6,   32'h0,        32'h00000001, 1'b0};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h5,   32'h0,        32'h00000001, 1'b0};
`endif
        vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 2'b11, 1'b0, 32'h0,   32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h00000000, 1'b0};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h404, 32'h0,        32'h00000001, 1'b0};

        dsel       = 1'b0;
        rst0       = 1'b1;
        rst3       = 1'b1;
        valid0     = 1'b0;
        valid3     = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        dsel = 1'b1;
        check_reset_outputs("rst3");
        dsel = 1'b0;
        @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;

        // Directed vectors, issued back-to-back in each RESP cycle
        for (int i = 0; i < 14; i++) begin
            model(0, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, erd, eer);
            do_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd,
                   vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Response is a single-cycle strobe; data/err drop back to zero
        @(posedge clk);
        #1;
        check_reset_outputs("after_resp");

        // Reset one cycle after accepting a store on the LATENCY=3 instance
        dsel = 1'b1;
        @(negedge clk);
        req_write = 1'b1;
        req_size  = 2'b10;
        req_signed = 1'b0;
        req_addr  = 32'h4;
        req_wdata = 32'h12345678;
        valid3    = 1'b1;
        @(posedge clk);
        #1;
        valid3 = 1'b0;
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst3 = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (m_rv) seen = 1'b1;
        end
        check("midrst.no_resp", {31'b0, seen}, 32'd0);
        model(1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, erd, eer);
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h00000001, 1'b0, "midrst.load");

        // Randomized accesses against the reference model
        for (int i = 0; i < 190; i++) begin
            dsel = (i >= 150);
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 32'h7FF);
            wd = $urandom;
            model(dsel ? 1 : 0, w, sz, sg, a, wd, erd, eer);
            do_req(w, sz, sg, a, wd, erd, eer, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
